// File: rtl/prog_mem_dump_pkg.sv
// Shared definitions for the accumulator core and its program-memory readback engine.
// Holds the dump FSM encoding plus the default address width and frame sync byte.
package tt_sky_pkg;

  localparam int         ADDR_W_DEF    = 7;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    LEN  = 3'd2,
    RD   = 3'd3,
    CAP  = 3'd4,
    DATA = 3'd5,
    CSUM = 3'd6
  } dump_state_t;

endpackage

// File: rtl/prog_mem_dump_if.sv
// Memory read port plus framed byte stream used by prog_mem_dump.
// The master side is the dump engine; the slave side is memory and stream sink.
interface prog_mem_dump_if
  import tt_sky_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic              out_last;

  modport master (
    output mem_rd_en,
    output mem_addr,
    input  mem_rdata,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output mem_rdata,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
  );

endinterface

// File: rtl/prog_mem_dump.sv
// Program-memory readback: streams SYNC, LEN, data bytes from a synchronous-read memory.
// Define PROG_MEM_DUMP_CSUM_EN to append an XOR checksum byte to every frame.
module prog_mem_dump
  import tt_sky_pkg::*;
#(
  parameter int         ADDR_W    = ADDR_W_DEF,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [7:0]        length,
  output logic              busy,
  output logic              done,
  prog_mem_dump_if.master   bus
);

`ifdef PROG_MEM_DUMP_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  dump_state_t       state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        count;
`ifdef PROG_MEM_DUMP_CSUM_EN
  logic [7:0]        csum;
`endif

  logic hs;
  assign hs = bus.out_valid && bus.out_ready;

  // Each data byte costs RD (issue read), CAP (memory latency), DATA (handshake).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr          <= '0;
      count         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.mem_rd_en <= 1'b0;
      bus.mem_addr  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
`ifdef PROG_MEM_DUMP_CSUM_EN
      csum          <= '0;
`endif
    end else begin
      done          <= 1'b0;
      bus.mem_rd_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            addr          <= start_addr;
            count         <= length;
`ifdef PROG_MEM_DUMP_CSUM_EN
            csum          <= '0;
`endif
            busy          <= 1'b1;
            bus.out_valid <= 1'b1;
            bus.out_data  <= SYNC_BYTE;
            bus.out_last  <= 1'b0;
            state         <= SYNC;
          end
        end

        SYNC: begin
          if (hs) begin
            bus.out_data <= count;
            bus.out_last <= (count == 8'd0) && !CSUM_EN;
            state        <= LEN;
          end
        end

        // LEN and DATA leave identically: fetch another byte or close the frame.
        LEN, DATA: begin
          if (hs) begin
            if (count != 8'd0) begin
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              bus.mem_rd_en <= 1'b1;
              bus.mem_addr  <= addr;
              state         <= RD;
            end else begin
`ifdef PROG_MEM_DUMP_CSUM_EN
              bus.out_data  <= csum;
              bus.out_last  <= 1'b1;
              state         <= CSUM;
`else
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
              state         <= IDLE;
`endif
            end
          end
        end

        RD: begin
          state <= CAP;
        end

        CAP: begin
          bus.out_data  <= bus.mem_rdata;
`ifdef PROG_MEM_DUMP_CSUM_EN
          csum          <= csum ^ bus.mem_rdata;
`endif
          addr          <= addr + 1'b1;
          count         <= count - 1'b1;
          bus.out_valid <= 1'b1;
          bus.out_last  <= (count == 8'd1) && !CSUM_EN;
          state         <= DATA;
        end

`ifdef PROG_MEM_DUMP_CSUM_EN
        CSUM: begin
          if (hs) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
            state         <= IDLE;
          end
        end
`endif

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_mem_dump.sv
// Scoreboard bench for prog_mem_dump: frames are predicted from a local memory image.
// Honours PROG_MEM_DUMP_CSUM_EN so the expected frames carry the checksum byte.
module tb_prog_mem_dump;
  import tt_sky_pkg::*;

  localparam int AW = 7;
`ifdef PROG_MEM_DUMP_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [7:0]    length = '0;
  logic          busy;
  logic          done;

  prog_mem_dump_if #(.ADDR_W(AW)) bus ();

  prog_mem_dump #(.ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_addr(start_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]    mem [128];
  logic [8:0]    exp_q [$];
  logic [AW-1:0] addr_q [$];
  int            checks = 0;
  int            errors = 0;
  int            rd_seen = 0;
  int            done_seen = 0;
  bit            mon_en = 1'b1;
  bit            stall_prev = 1'b0;

  // Synchronous-read memory model with one cycle of latency.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [AW-1:0] a, input logic [7:0] n);
    logic [7:0]    x;
    logic [7:0]    d;
    logic [AW-1:0] p;
    x = 8'h00;
    p = a;
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({(n == 8'd0) && !CSUM_ON, n});
    for (int i = 0; i < int'(n); i++) begin
      d = mem[p];
      x = x ^ d;
      addr_q.push_back(p);
      exp_q.push_back({(i == int'(n) - 1) && !CSUM_ON, d});
      p = p + 7'd1;
    end
    if (CSUM_ON) exp_q.push_back({1'b1, x});
  endtask

  // Stream monitor: every presented byte must equal the scoreboard head, so a stalled byte stays put.
  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.mem_rd_en) begin
        rd_seen++;
        check_output("rd_pending", 32'(addr_q.size() != 0), 32'd1);
        if (addr_q.size() != 0) check_output("mem_addr", 32'(bus.mem_addr), 32'(addr_q.pop_front()));
      end
      if (stall_prev) check_output("stall_valid", 32'(bus.out_valid), 32'd1);
      if (bus.out_valid) begin
        check_output("stream_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check_output("out_data", 32'(bus.out_data), 32'(exp_q[0][7:0]));
          check_output("out_last", 32'(bus.out_last), 32'(exp_q[0][8]));
          if (bus.out_ready) exp_q.delete(0);
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      if (done) done_seen++;
    end
  end

  // mode 0: sink always ready; mode 1: ~50% random backpressure. glitch re-pulses start mid-frame.
  task automatic apply_stimulus(input logic [AW-1:0] a, input logic [7:0] n, input int mode, input bit glitch);
    bit got_done;
    push_frame(a, n);
    rd_seen   = 0;
    done_seen = 0;
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = a;
    length     = n;
    @(posedge clk); #1;
    start      = 1'b0;
    start_addr = 7'($urandom);
    length     = 8'($urandom);
    check_output("busy_after_start", 32'(busy), 32'd1);
    got_done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
      bus.out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (glitch && cyc == 4) begin
        start      = 1'b1;
        start_addr = 7'h40;
        length     = 8'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        got_done = 1'b1;
        check_output("busy_at_done", 32'(busy), 32'd0);
      end
    end
    start         = 1'b0;
    bus.out_ready = 1'b1;
    check_output("frame_timeout", 32'(got_done), 32'd1);
    @(posedge clk); #1;
    check_output("done_pulse_width", 32'(done), 32'd0);
    check_output("done_count", 32'(done_seen), 32'd1);
    check_output("bytes_left", 32'(exp_q.size()), 32'd0);
    check_output("reads_left", 32'(addr_q.size()), 32'd0);
    check_output("rd_en_count", 32'(rd_seen), 32'(n));
    check_output("idle_valid", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic reset_mid_frame();
    int total;
    bit seen;
    push_frame(7'h48, 8'd8);
    total = exp_q.size();
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    start         = 1'b1;
    start_addr    = 7'h48;
    length        = 8'd8;
    @(posedge clk); #1;
    start = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (exp_q.size() <= total - 2) bus.out_ready = 1'b0;
      @(posedge clk); #1;
      if (exp_q.size() <= total - 2 && bus.out_valid) seen = 1'b1;
    end
    check_output("reached_data", 32'(seen), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check_output("rst_out_last", 32'(bus.out_last), 32'd0);
    mon_en = 1'b0;
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n         = 1'b1;
    mon_en        = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check_output("post_rst_quiet", 32'({bus.out_valid, busy, bus.mem_rd_en}), 32'd0);
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i * 7 + 3);

    repeat (3) @(posedge clk);
    #1;
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check_output("reset_valid", 32'(bus.out_valid), 32'd0);
    check_output("reset_last", 32'(bus.out_last), 32'd0);
    check_output("reset_data", 32'(bus.out_data), 32'd0);
    check_output("reset_addr", 32'(bus.mem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic 4-byte frame");
    mem[0] = 8'h10; mem[1] = 8'h11; mem[2] = 8'h12; mem[3] = 8'h13;
    apply_stimulus(7'h00, 8'd4, 0, 1'b0);

    $display("[TB] zero-length frame");
    apply_stimulus(7'h10, 8'd0, 0, 1'b0);

    $display("[TB] address wrap");
    mem[7'h7E] = 8'hAA; mem[7'h7F] = 8'hBB; mem[7'h00] = 8'hCC;
    apply_stimulus(7'h7E, 8'd3, 0, 1'b0);

    $display("[TB] 16-byte dump under random backpressure");
    for (int i = 0; i < 16; i++) mem[7'h20 + i] = 8'($urandom);
    apply_stimulus(7'h20, 8'd16, 1, 1'b0);

    $display("[TB] start re-pulsed while busy");
    apply_stimulus(7'h30, 8'd5, 0, 1'b1);

    $display("[TB] reset during DATA then clean frame");
    reset_mid_frame();
    apply_stimulus(7'h05, 8'd3, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
